// File: rtl/gpu_pkg.sv
// gpu_pkg: shared texel formats, fetch FSM states and address width
package gpu_pkg;
  localparam int ADR_W_DEF = 19;
  localparam logic [1:0] PIX_4BIT = 2'd0;
  localparam logic [1:0] PIX_8BIT = 2'd1;
  localparam logic [1:0] PIX_16BIT = 2'd2;
  localparam logic [1:0] PIX_RESERVED = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_TEX_REQ,
    S_TEX_WAIT,
    S_CLUT_REQ,
    S_CLUT_WAIT,
    S_OUT
  } state_e;
endpackage

// File: rtl/tex_index_extract.sv
// tex_index_extract: picks the palette index out of a VRAM halfword; 16bpp/reserved pass through
module tex_index_extract import gpu_pkg::*; (
  input  logic [15:0] data,
  input  logic [1:0]  sub,
  input  logic [1:0]  fmt,
  output logic [7:0]  idx,
  output logic        is16
);
  always_comb begin
    is16 = fmt[1];
    idx = fmt == PIX_4BIT ? {4'h0, data[{sub, 2'b00} +: 4]} : (sub[0] ? data[15:8] : data[7:0]);
  end
endmodule

// File: rtl/tex_fetch_unit.sv
// tex_fetch_unit: fetches one texel from VRAM, resolves paletted formats through the CLUT
// with a single-entry hit register, and hands a 5:5:5:1 color to the pixel pipeline.
module tex_fetch_unit import gpu_pkg::*; #(
  parameter int ADR_W = ADR_W_DEF,
  parameter bit CLUT_CACHE = 1'b1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_texValid,
  output logic             o_texReady,
  input  logic [ADR_W-1:0] i_texAdr,
  input  logic [1:0]       i_subSel,
  input  logic [1:0]       i_texFormat,
  input  logic [5:0]       i_clutX,
  input  logic [8:0]       i_clutY,
  input  logic             i_clutInval,
  output logic             o_memReq,
  output logic [ADR_W-1:0] o_memAdr,
  input  logic             i_memAck,
  input  logic             i_memDValid,
  input  logic [15:0]      i_memData,
  output logic             o_colValid,
  input  logic             i_colReady,
  output logic [15:0]      o_color,
  output logic             o_transparent
);
  state_e state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d, hit_adr_q, hit_adr_d, clut_adr;
  logic [1:0] sub_q, sub_d, fmt_q, fmt_d;
  logic [5:0] clutx_q, clutx_d;
  logic [8:0] cluty_q, cluty_d;
  logic [15:0] color_q, color_d, hit_data_q, hit_data_d;
  logic hit_vld_q, hit_vld_d, is16, hit;
  logic [7:0] idx;
  logic [9:0] clut_x;
  tex_index_extract u_idx (.data(i_memData), .sub(sub_q), .fmt(fmt_q), .idx(idx), .is16(is16));
  // X wraps inside the CLUT line; Y never sees a carry
  assign clut_x = {clutx_q, 4'b0000} + {2'b00, idx};
  assign clut_adr = ADR_W'({cluty_q, clut_x});
  assign hit = CLUT_CACHE && hit_vld_q && !i_clutInval && hit_adr_q == clut_adr;
  assign o_texReady = state_q == S_IDLE;
  assign o_memReq = state_q == S_TEX_REQ || state_q == S_CLUT_REQ;
  assign o_memAdr = adr_q;
  assign o_colValid = state_q == S_OUT;
  assign o_color = color_q;
  assign o_transparent = o_colValid && color_q == 16'h0000;
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    sub_d = sub_q;
    fmt_d = fmt_q;
    clutx_d = clutx_q;
    cluty_d = cluty_q;
    color_d = color_q;
    hit_adr_d = hit_adr_q;
    hit_data_d = hit_data_q;
    hit_vld_d = hit_vld_q && !i_clutInval;
    case (state_q)
      S_IDLE: if (i_texValid) begin
        adr_d = i_texAdr;
        sub_d = i_subSel;
        fmt_d = i_texFormat;
        clutx_d = i_clutX;
        cluty_d = i_clutY;
        state_d = S_TEX_REQ;
      end
      S_TEX_REQ: state_d = i_memAck ? S_TEX_WAIT : S_TEX_REQ;
      S_TEX_WAIT: if (i_memDValid) begin
        color_d = is16 ? i_memData : hit_data_q;
        adr_d = is16 || hit ? adr_q : clut_adr;
        state_d = is16 || hit ? S_OUT : S_CLUT_REQ;
      end
      S_CLUT_REQ: state_d = i_memAck ? S_CLUT_WAIT : S_CLUT_REQ;
      S_CLUT_WAIT: if (i_memDValid) begin
        color_d = i_memData;
        hit_adr_d = adr_q;
        hit_data_d = i_memData;
        hit_vld_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: state_d = i_colReady ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      adr_q <= '0;
      sub_q <= '0;
      fmt_q <= '0;
      clutx_q <= '0;
      cluty_q <= '0;
      color_q <= '0;
      hit_adr_q <= '0;
      hit_data_q <= '0;
      hit_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      sub_q <= sub_d;
      fmt_q <= fmt_d;
      clutx_q <= clutx_d;
      cluty_q <= cluty_d;
      color_q <= color_d;
      hit_adr_q <= hit_adr_d;
      hit_data_q <= hit_data_d;
      hit_vld_q <= hit_vld_d;
    end
  end
endmodule

// File: tb/tb_tex_fetch_unit.sv
// tb_tex_fetch_unit: scoreboard bench with a VRAM/arbiter model and a reference CLUT cache
module tb_tex_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_rst = 1'b1, i_texValid = 1'b0, o_texReady, i_clutInval = 1'b0;
  logic [18:0] i_texAdr = '0, o_memAdr, pend_adr = '0, last_req = '0;
  logic [1:0] i_subSel = '0, i_texFormat = '0;
  logic [5:0] i_clutX = '0;
  logic [8:0] i_clutY = '0;
  logic o_memReq, i_memAck, i_memDValid, o_colValid, i_colReady = 1'b0, o_transparent;
  logic [15:0] i_memData, o_color;
  tex_fetch_unit dut (
    .clk(clk), .i_rst(i_rst), .i_texValid(i_texValid), .o_texReady(o_texReady),
    .i_texAdr(i_texAdr), .i_subSel(i_subSel), .i_texFormat(i_texFormat),
    .i_clutX(i_clutX), .i_clutY(i_clutY), .i_clutInval(i_clutInval),
    .o_memReq(o_memReq), .o_memAdr(o_memAdr), .i_memAck(i_memAck),
    .i_memDValid(i_memDValid), .i_memData(i_memData), .o_colValid(o_colValid),
    .i_colReady(i_colReady), .o_color(o_color), .o_transparent(o_transparent)
  );
  int cyc = 0, xfer = 0, checks = 0, passes = 0;
  int ack_stall = 0, req_cnt = 0;
  bit pend = 0, drop = 0, force_dv = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_colValid && i_colReady) xfer <= xfer + 1;
  end
  logic [15:0] vram [int];
  function automatic logic [15:0] rd(input logic [18:0] a);
    return vram.exists(int'(a)) ? vram[int'(a)] : (a[15:0] ^ 16'h5A5A);
  endfunction
  // arbiter model: acks after ack_stall request cycles, returns data one cycle after the ack
  initial begin
    i_memAck = 1'b0;
    i_memDValid = 1'b0;
    i_memData = '0;
    forever begin
      @(negedge clk);
      i_memDValid = (pend && !drop) || force_dv;
      i_memData = force_dv ? 16'hDEAD : rd(pend_adr);
      pend = 0;
      if (i_rst) i_memAck = 1'b0;
      else if (o_memReq && ack_stall == 0) begin
        i_memAck = 1'b1;
        pend = 1;
        pend_adr = o_memAdr;
        last_req = o_memAdr;
        req_cnt++;
      end else begin
        i_memAck = 1'b0;
        if (o_memReq) ack_stall--;
      end
    end
  end
  bit m_hit_vld = 0;
  logic [18:0] m_hit_adr = '0;
  logic [15:0] sb_q[$];
  logic [15:0] r_col, r_exp;
  logic r_trans;
  int r_lat, r_reqs, r_exp_reqs;
  bit r_rdy, r_adr_bad, r_col_bad, r_to;
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic run_texel(input logic [18:0] adr, input logic [1:0] sub, input logic [1:0] fmt,
                           input logic [5:0] cx, input logic [8:0] cy, input int col_stall);
    logic [15:0] t, e;
    logic [7:0] idx;
    logic [9:0] x;
    logic [18:0] ca, prev_adr;
    bit prev_req;
    int acc, r0;
    t = rd(adr);
    if (fmt[1]) begin
      e = t;
      r_exp_reqs = 1;
    end else begin
      idx = fmt == 2'd0 ? 8'((t >> (4 * sub)) & 16'hF) : (sub[0] ? t[15:8] : t[7:0]);
      x = 10'((int'(cx) * 16 + int'(idx)) % 1024);
      ca = 19'(int'(cy) * 1024 + int'(x));
      e = rd(ca);
      r_exp_reqs = (m_hit_vld && m_hit_adr == ca) ? 1 : 2;
      m_hit_vld = 1;
      m_hit_adr = ca;
    end
    sb_q.push_back(e);
    r_rdy = 0; r_adr_bad = 0; r_col_bad = 0; r_to = 0; r_lat = -1;
    r0 = req_cnt;
    tick;
    i_texValid = 1'b1; i_texAdr = adr; i_subSel = sub; i_texFormat = fmt; i_clutX = cx; i_clutY = cy;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) if (o_texReady) acc = cyc; else tick;
    tick;
    i_texValid = 1'b0;
    prev_req = 0;
    prev_adr = '0;
    for (int i = 0; i < 60 && !o_colValid; i++) begin
      if (o_texReady) r_rdy = 1;
      if (o_memReq && prev_req && o_memAdr !== prev_adr) r_adr_bad = 1;
      prev_req = o_memReq;
      prev_adr = o_memAdr;
      tick;
    end
    r_exp = sb_q.pop_front();
    if (acc < 0 || !o_colValid) begin
      r_to = 1;
      return;
    end
    r_lat = cyc - acc;
    r_col = o_color;
    r_trans = o_transparent;
    repeat (col_stall) begin
      tick;
      if (!o_colValid || o_color !== r_col) r_col_bad = 1;
      if (o_texReady) r_rdy = 1;
    end
    i_colReady = 1'b1;
    tick;
    i_colReady = 1'b0;
    r_reqs = req_cnt - r0;
  endtask
  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) tick;
    i_rst = 1'b0;
    m_hit_vld = 0;
    tick;
    checks++; if (o_texReady !== 1'b1) $display("FAIL reset_texReady got %b want 1", o_texReady); else passes++;
    checks++; if ({o_memReq, o_colValid, o_transparent} !== 3'b000) $display("FAIL reset_flags got %b want 000", {o_memReq, o_colValid, o_transparent}); else passes++;
    checks++; if ({o_color, o_memAdr} !== 35'h0) $display("FAIL reset_buses got %h want 0", {o_color, o_memAdr}); else passes++;
  endtask
  task automatic test_16bpp;
    vram[32'h40] = 16'h7C1F;
    vram[32'h41] = 16'h0000;
    run_texel(19'h00040, 2'd3, 2'd2, 6'd0, 9'd0, 0);
    checks++; if (r_to) $display("FAIL 16bpp_timeout got timeout want color"); else passes++;
    checks++; if (r_col !== 16'h7C1F || r_col !== r_exp) $display("FAIL 16bpp_color got %h want %h", r_col, r_exp); else passes++;
    checks++; if (r_lat !== 3 || r_reqs !== r_exp_reqs) $display("FAIL 16bpp_timing got lat %0d reqs %0d want 3 %0d", r_lat, r_reqs, r_exp_reqs); else passes++;
    run_texel(19'h00041, 2'd0, 2'd3, 6'd5, 9'd5, 0);
    checks++; if (r_col !== r_exp || r_trans !== 1'b1 || r_reqs !== 1) $display("FAIL reserved_transp got %h/%b/%0d want %h/1/1", r_col, r_trans, r_reqs, r_exp); else passes++;
  endtask
  task automatic test_4bpp;
    vram[32'h100] = 16'hA5C3;
    vram[480 * 1024 + 21] = 16'h8000;
    run_texel(19'h00100, 2'd2, 2'd0, 6'd1, 9'd480, 0);
    checks++; if (r_col !== 16'h8000 || r_col !== r_exp || r_trans !== 1'b0) $display("FAIL 4bpp_color got %h/%b want %h/0", r_col, r_trans, r_exp); else passes++;
    checks++; if (last_req !== {9'd480, 10'd21}) $display("FAIL 4bpp_clut_adr got %h want %h", last_req, {9'd480, 10'd21}); else passes++;
    checks++; if (r_lat !== 5 || r_reqs !== 2) $display("FAIL 4bpp_timing got lat %0d reqs %0d want 5 2", r_lat, r_reqs); else passes++;
  endtask
  task automatic test_8bpp_wrap;
    vram[32'h200] = 16'hF000;
    vram[7 * 1024 + 224] = 16'h1234;
    run_texel(19'h00200, 2'd1, 2'd1, 6'd63, 9'd7, 0);
    checks++; if (last_req !== {9'd7, 10'd224}) $display("FAIL 8bpp_wrap_adr got %h want %h", last_req, {9'd7, 10'd224}); else passes++;
    checks++; if (r_col !== 16'h1234 || r_col !== r_exp || r_reqs !== 2) $display("FAIL 8bpp_wrap_color got %h/%0d want %h/2", r_col, r_reqs, r_exp); else passes++;
  endtask
  task automatic test_hit_inval;
    run_texel(19'h00100, 2'd2, 2'd0, 6'd1, 9'd480, 0);
    checks++; if (r_col !== r_exp || r_reqs !== 2 || r_lat !== 5) $display("FAIL hit_first got %h/%0d/%0d want %h/2/5", r_col, r_reqs, r_lat, r_exp); else passes++;
    run_texel(19'h00100, 2'd2, 2'd0, 6'd1, 9'd480, 0);
    checks++; if (r_col !== 16'h8000 || r_col !== r_exp) $display("FAIL hit_color got %h want %h", r_col, r_exp); else passes++;
    checks++; if (r_reqs !== 1 || r_reqs !== r_exp_reqs || r_lat !== 3) $display("FAIL hit_timing got reqs %0d lat %0d want 1 3", r_reqs, r_lat); else passes++;
    tick;
    i_clutInval = 1'b1;
    tick;
    i_clutInval = 1'b0;
    m_hit_vld = 0;
    run_texel(19'h00100, 2'd2, 2'd0, 6'd1, 9'd480, 0);
    checks++; if (r_reqs !== 2 || r_lat !== 5 || last_req !== {9'd480, 10'd21}) $display("FAIL inval_reissue got reqs %0d lat %0d adr %h want 2 5 %h", r_reqs, r_lat, last_req, {9'd480, 10'd21}); else passes++;
    checks++; if (r_col !== r_exp) $display("FAIL inval_color got %h want %h", r_col, r_exp); else passes++;
  endtask
  task automatic test_backpressure;
    int x0;
    vram[32'h300] = 16'h0421;
    x0 = xfer;
    ack_stall = 4;
    run_texel(19'h00300, 2'd0, 2'd2, 6'd0, 9'd0, 3);
    checks++; if (r_col !== 16'h0421 || r_col !== r_exp || r_to) $display("FAIL bp_color got %h want %h", r_col, r_exp); else passes++;
    checks++; if (r_lat !== 7 || r_reqs !== 1) $display("FAIL bp_timing got lat %0d reqs %0d want 7 1", r_lat, r_reqs); else passes++;
    checks++; if ({r_rdy, r_adr_bad, r_col_bad} !== 3'b000) $display("FAIL bp_stable got rdy/adr/col %b want 000", {r_rdy, r_adr_bad, r_col_bad}); else passes++;
    checks++; if (xfer - x0 !== 1) $display("FAIL bp_xfer got %0d want 1", xfer - x0); else passes++;
    checks++; if (o_colValid !== 1'b0 || o_texReady !== 1'b1) $display("FAIL bp_return got colValid %b texReady %b want 0 1", o_colValid, o_texReady); else passes++;
  endtask
  task automatic test_reset_mid;
    bit seen;
    seen = 0;
    drop = 1;
    tick;
    i_texValid = 1'b1; i_texAdr = 19'h00040; i_texFormat = 2'd2;
    tick;
    i_texValid = 1'b0;
    tick;
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    m_hit_vld = 0;
    tick;
    force_dv = 1;
    tick;
    force_dv = 0;
    drop = 0;
    repeat (5) begin
      if (o_colValid) seen = 1;
      tick;
    end
    checks++; if (seen || o_texReady !== 1'b1 || o_memReq !== 1'b0) $display("FAIL stale_ignored got colValid %b texReady %b memReq %b want 0 1 0", seen, o_texReady, o_memReq); else passes++;
    run_texel(19'h00100, 2'd2, 2'd0, 6'd1, 9'd480, 0);
    checks++; if (r_reqs !== 2 || r_col !== r_exp) $display("FAIL reset_clears_hit got reqs %0d color %h want 2 %h", r_reqs, r_col, r_exp); else passes++;
  endtask
  initial begin
    test_reset;
    test_16bpp;
    test_4bpp;
    test_8bpp_wrap;
    test_hit_inval;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
